// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared GPIO interrupt definitions: pin count, trigger-type encodings and
// the per-pin event decode used by the interrupt controller.
`ifndef GPIO_PIN_NUM
`define GPIO_PIN_NUM 8
`endif
`ifndef GPIO_INT_LVL_HI
`define GPIO_INT_LVL_HI 2'b00
`endif
`ifndef GPIO_INT_LVL_LO
`define GPIO_INT_LVL_LO 2'b01
`endif
`ifndef GPIO_INT_RISE
`define GPIO_INT_RISE 2'b10
`endif
`ifndef GPIO_INT_FALL
`define GPIO_INT_FALL 2'b11
`endif

package gpio_irq_ctrl_pkg;

  // Trigger type, encoded as {INTTYPE1, INTTYPE0}.
  typedef enum logic [1:0] {
    INT_LVL_HI = `GPIO_INT_LVL_HI,
    INT_LVL_LO = `GPIO_INT_LVL_LO,
    INT_RISE   = `GPIO_INT_RISE,
    INT_FALL   = `GPIO_INT_FALL
  } int_type_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  // Event for one pin given its filtered value and that value one cycle ago.
  function automatic logic detect_event(input int_type_e typ,
                                        input logic filt,
                                        input logic filt_prev);
    logic evt;
    evt = 1'b0;
    case (typ)
      INT_LVL_HI: evt = filt;
      INT_LVL_LO: evt = ~filt;
      INT_RISE:   evt = filt & ~filt_prev;
      INT_FALL:   evt = ~filt & filt_prev;
      default:    evt = 1'b0;
    endcase
    return evt;
  endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// One pad input: metastability synchroniser, debounce counter, filtered
// value and its one-cycle delayed copy for edge detection.
module gpio_pin_filter
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_i,
  input  logic [DEB_W-1:0] deb_cnt_i,
  output logic             filt_o,
  output logic             filt_prev_o
);

  // Depth below the minimum is clamped so the chain is always at least two flops.
  localparam int unsigned STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic              filt_q, filt_d;
  logic              filt_prev_q;
  logic              sync;

  assign sync = sync_q[STAGES-1];

  // Next state: shift the pad into the chain; commit sync to filt only after
  // deb_cnt_i+1 consecutive differing cycles. cnt tops out at the largest
  // possible threshold, so it cannot wrap.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pad_i};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= deb_cnt_i) begin
      filt_d = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  // State registers; reset also discards any debounce in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign filt_o      = filt_q;
  assign filt_prev_o = filt_prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input conditioning and interrupt controller: per-pin filtering,
// level/edge event detection, sticky clear-on-read status and a single irq.
module gpio_irq_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int unsigned GPIO_NUM    = `GPIO_PIN_NUM,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  input  logic [GPIO_NUM-1:0] inten_i,
  input  logic [GPIO_NUM-1:0] inttype0_i,
  input  logic [GPIO_NUM-1:0] inttype1_i,
  input  logic [DEB_W-1:0]    deb_cnt_i,
  input  logic                stat_rd_i,
  output logic [GPIO_NUM-1:0] gpio_in_o,
  output logic [GPIO_NUM-1:0] stat_o,
  output logic                irq_o
);

  logic [GPIO_NUM-1:0] filt_w, filt_prev_w;
  logic [GPIO_NUM-1:0] evt, stat_q, stat_d;
  logic                irq_q;

  for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_filter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pad_i      (gpio_in_i[g]),
      .deb_cnt_i  (deb_cnt_i),
      .filt_o     (filt_w[g]),
      .filt_prev_o(filt_prev_w[g])
    );
  end

  // Event decode per pin, then status update. A set wins over a
  // simultaneous read-clear so no event is lost.
  always_comb begin
    evt = '0;
    for (int i = 0; i < GPIO_NUM; i++) begin
      evt[i] = detect_event(int_type_e'({inttype1_i[i], inttype0_i[i]}),
                            filt_w[i], filt_prev_w[i]);
    end
    stat_d = (stat_q & ~{GPIO_NUM{stat_rd_i}}) | (evt & inten_i);
  end

  // Sticky status and a registered irq so the interrupt line never glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      irq_q  <= |stat_d;
    end
  end

  assign gpio_in_o = filt_w;
  assign stat_o    = stat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl. The driver applies pad/config stimulus
// and queues the hand-derived {gpio_in_o, stat_o, irq_o} expected at a given
// cycle; an independent monitor pops and compares on the falling edge.
module tb_gpio_irq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] gpio_in_i, inten_i, inttype0_i, inttype1_i;
  logic [7:0] deb_cnt_i;
  logic       stat_rd_i;
  logic [7:0] gpio_in_o, stat_o;
  logic       irq_o;

  gpio_irq_ctrl dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .gpio_in_i (gpio_in_i),
    .inten_i   (inten_i),
    .inttype0_i(inttype0_i),
    .inttype1_i(inttype1_i),
    .deb_cnt_i (deb_cnt_i),
    .stat_rd_i (stat_rd_i),
    .gpio_in_o (gpio_in_o),
    .stat_o    (stat_o),
    .irq_o     (irq_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];   // {gpio_in_o, stat_o, irq_o}
  int          cyc_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          drv_done = 1'b0;

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk_i) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      logic [16:0] e;
      logic [16:0] a;
      string       nm;
      int          c;
      e  = exp_q.pop_front();
      c  = cyc_q.pop_front();
      nm = name_q.pop_front();
      a  = {gpio_in_o, stat_o, irq_o};
      n_vec++;
      if (c != cyc) begin
        n_bad++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", nm, c, cyc);
      end else if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got pad=%h stat=%h irq=%b, want pad=%h stat=%h irq=%b",
                 nm, a[16:9], a[8:1], a[0], e[16:9], e[8:1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [7:0] pad,
                            input logic [7:0] stat, input logic irq);
    exp_q.push_back({pad, stat, irq});
    cyc_q.push_back(cyc);
    name_q.push_back(nm);
  endtask

  task automatic read_stat();
    stat_rd_i = 1'b1;
    step(1);
    stat_rd_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; gpio_in_i = '0; inten_i = '0; inttype0_i = '0; inttype1_i = '0;
    deb_cnt_i = '0; stat_rd_i = 1'b0;
    step(2);
    expect_now("reset_state", 8'h00, 8'h00, 1'b0);
    rst_i = 1'b0;
    step(2);
    expect_now("idle_after_reset", 8'h00, 8'h00, 1'b0);

    // Rising edge on pin 0, bypass debounce: pad after 3 edges, stat after 4.
    inttype1_i = 8'h01; inten_i = 8'h01;
    gpio_in_i = 8'h01;
    step(3);
    expect_now("rise_pad_edge3", 8'h01, 8'h00, 1'b0);
    step(1);
    expect_now("rise_stat_edge4", 8'h01, 8'h01, 1'b1);
    read_stat();
    expect_now("rise_cleared", 8'h01, 8'h00, 1'b0);
    step(3);
    expect_now("rise_no_reset", 8'h01, 8'h00, 1'b0);

    // Level low on pin 3 while held low: still active, so a read cannot clear it.
    inttype0_i = 8'h08; inten_i = 8'h08;
    step(1);
    expect_now("lvl_lo_set", 8'h01, 8'h08, 1'b1);
    read_stat();
    expect_now("lvl_lo_reasserted", 8'h01, 8'h08, 1'b1);
    gpio_in_i = 8'h09;
    step(3);
    expect_now("lvl_lo_pad_high", 8'h09, 8'h08, 1'b1);
    read_stat();
    expect_now("lvl_lo_cleared", 8'h09, 8'h00, 1'b0);
    step(2);
    expect_now("lvl_lo_stays_clear", 8'h09, 8'h00, 1'b0);

    // Debounce 5: a 5-cycle pulse is rejected, a 6-cycle pulse passes.
    deb_cnt_i = 8'd5; inttype1_i = 8'h05; inten_i = 8'h04;
    gpio_in_i = 8'h0D;
    step(5);
    gpio_in_i = 8'h09;
    step(8);
    expect_now("deb_short_reject", 8'h09, 8'h00, 1'b0);
    gpio_in_i = 8'h0D;
    step(6);
    gpio_in_i = 8'h09;
    step(1);
    expect_now("deb_long_edge7", 8'h09, 8'h00, 1'b0);
    step(1);
    expect_now("deb_long_edge8", 8'h0D, 8'h00, 1'b0);
    step(1);
    expect_now("deb_long_stat", 8'h0D, 8'h04, 1'b1);
    read_stat();
    expect_now("deb_cleared", 8'h0D, 8'h00, 1'b0);
    step(6);
    expect_now("deb_fall_commit", 8'h09, 8'h00, 1'b0);

    // Simultaneous set (pin 7 falling) and clear while stat = 01.
    deb_cnt_i = 8'd0; inten_i = 8'h00;
    gpio_in_i = 8'h88;
    step(4);
    expect_now("sim_prep", 8'h88, 8'h00, 1'b0);
    inttype1_i = 8'h85; inttype0_i = 8'h88; inten_i = 8'h81;
    gpio_in_i = 8'h89;
    step(4);
    expect_now("sim_stat01", 8'h89, 8'h01, 1'b1);
    gpio_in_i = 8'h09;
    step(3);
    stat_rd_i = 1'b1;
    step(1);
    stat_rd_i = 1'b0;
    expect_now("sim_set_wins", 8'h09, 8'h80, 1'b1);
    read_stat();
    expect_now("sim_cleared", 8'h09, 8'h00, 1'b0);

    // Masking: no sets with inten = 0; disabling inten keeps a set bit.
    inten_i = 8'h00;
    gpio_in_i = 8'hF6;
    step(5);
    expect_now("mask_toggle_up", 8'hF6, 8'h00, 1'b0);
    gpio_in_i = 8'h09;
    step(5);
    expect_now("mask_toggle_dn", 8'h09, 8'h00, 1'b0);
    inttype1_i = 8'h95; inten_i = 8'h10;
    gpio_in_i = 8'h19;
    step(4);
    expect_now("mask_bit4_set", 8'h19, 8'h10, 1'b1);
    inten_i = 8'h00;
    step(3);
    expect_now("mask_bit4_held", 8'h19, 8'h10, 1'b1);
    read_stat();
    expect_now("mask_bit4_read", 8'h19, 8'h00, 1'b0);

    // Reset mid-debounce with stat = FF; count must restart from zero.
    inttype0_i = 8'h00; inttype1_i = 8'h00; inten_i = 8'hFF;
    gpio_in_i = 8'hFF;
    step(4);
    expect_now("rst_prep_ff", 8'hFF, 8'hFF, 1'b1);
    deb_cnt_i = 8'd10;
    gpio_in_i = 8'h00;
    step(5);
    expect_now("rst_mid_count", 8'hFF, 8'hFF, 1'b1);
    rst_i = 1'b1;
    gpio_in_i = 8'hFF;
    step(1);
    expect_now("rst_all_zero", 8'h00, 8'h00, 1'b0);
    rst_i = 1'b0;
    step(12);
    expect_now("rst_cnt_restart", 8'h00, 8'h00, 1'b0);
    step(1);
    expect_now("rst_commit", 8'hFF, 8'h00, 1'b0);
    step(1);
    expect_now("rst_lvl_set", 8'hFF, 8'hFF, 1'b1);

    step(2);
    drv_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    wait (drv_done);
    step(2);
    while (cyc_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(cyc_q.pop_front());
      n_vec++;
      n_bad++;
      $display("FAIL unchecked_%s: expectation never compared", name_q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
